// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver running entirely on the system
// clock. It synchronises and deglitches the raw pins and decodes 11-bit
// frames (start, 8 data LSB-first, odd parity, stop). A watchdog aborts
// stalled frames. Good bytes land in a first-word-fall-through FIFO.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   ps2_clk, ps2_dat  raw asynchronous PS/2 pins
//   rd_ready          consumer takes rd_data this cycle (pop when rd_valid)
//   err_clr           one-cycle pulse clearing the sticky error flags
//   rd_valid          FIFO non-empty
//   rd_data           FIFO head byte (combinational, 0 when empty)
//   fifo_count        bytes currently stored
//   parity_err        sticky: a frame failed odd parity
//   frame_err         sticky: bad stop bit or watchdog abort
//   overflow          sticky: a good byte was dropped, FIFO full
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  ps2_clk,
    input  logic                                  ps2_dat,
    input  logic                                  rd_ready,
    input  logic                                  err_clr,
    output logic                                  rd_valid,
    output logic [7:0]                            rd_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_count,
    output logic                                  parity_err,
    output logic                                  frame_err,
    output logic                                  overflow
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int FW  = $clog2(FILTER_LEN + 1);
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [FW-1:0]  FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [WDW-1:0] WD_LAST   = WDW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]  DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // ------------------------------------------------------------------
    // Input synchronisers and clock deglitch filter
    // ------------------------------------------------------------------
    logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic          r_filt, r_filt_d;
    logic [FW-1:0] r_filt_cnt;
    logic          w_fall;

    // Idle-high reset values keep the sync chain from faking a falling edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_dat;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // Filtered clock follows only after FILTER_LEN consecutive disagreeing
    // samples; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_filt     <= 1'b1;
            r_filt_d   <= 1'b1;
            r_filt_cnt <= '0;
        end else begin
            r_filt_d <= r_filt;
            if (r_clk_s2 != r_filt) begin
                if (r_filt_cnt == FILT_LAST) begin
                    r_filt     <= r_clk_s2;
                    r_filt_cnt <= '0;
                end else begin
                    r_filt_cnt <= r_filt_cnt + FW'(1);
                end
            end else begin
                r_filt_cnt <= '0;
            end
        end
    end

    assign w_fall = r_filt_d & ~r_filt;

    // ------------------------------------------------------------------
    // Frame decoder FSM
    // ------------------------------------------------------------------
    state_t         r_state, w_state_next;
    logic [7:0]     r_shift;
    logic [2:0]     r_bitcnt;
    logic           r_par;
    logic [WDW-1:0] r_wd;
    logic           w_start, w_shift, w_cap_par, w_eval, w_timeout;

    // A falling edge in the same cycle wins over the watchdog expiring
    assign w_timeout = (r_state != IDLE) && !w_fall && (r_wd == WD_LAST);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_shift      = 1'b0;
        w_cap_par    = 1'b0;
        w_eval       = 1'b0;
        if (w_timeout) begin
            w_state_next = IDLE;
        end else if (w_fall) begin
            case (r_state)
                IDLE: begin
                    if (!r_dat_s2) begin
                        w_start      = 1'b1;
                        w_state_next = DATA;
                    end
                end
                DATA: begin
                    w_shift = 1'b1;
                    if (r_bitcnt == 3'd7) w_state_next = PARITY;
                end
                PARITY: begin
                    w_cap_par    = 1'b1;
                    w_state_next = STOP;
                end
                STOP: begin
                    w_eval       = 1'b1;
                    w_state_next = IDLE;
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_par    <= 1'b0;
            r_wd     <= '0;
        end else begin
            if (w_start) begin
                r_shift  <= '0;
                r_bitcnt <= '0;
            end
            if (w_shift) begin
                r_shift  <= {r_dat_s2, r_shift[7:1]};
                r_bitcnt <= r_bitcnt + 3'd1;
            end
            if (w_cap_par) r_par <= r_dat_s2;
            // Watchdog counts cycles since the last fall while mid-frame
            if (r_state == IDLE || w_fall) r_wd <= '0;
            else                           r_wd <= r_wd + WDW'(1);
        end
    end

    // Data plus parity must hold an odd number of ones
    logic w_par_ok, w_push_req, w_perr_set, w_ferr_set;
    assign w_par_ok   = ^{r_shift, r_par};
    assign w_push_req = w_eval & r_dat_s2 & w_par_ok;
    assign w_perr_set = w_eval & ~w_par_ok;
    assign w_ferr_set = (w_eval & ~r_dat_s2) | w_timeout;

    // ------------------------------------------------------------------
    // FWFT FIFO
    // ------------------------------------------------------------------
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic          w_pop, w_push, w_ovf_set;

    assign rd_valid   = (r_count != '0);
    assign rd_data    = rd_valid ? r_mem[r_rptr] : 8'h00;
    assign fifo_count = r_count;

    assign w_pop     = rd_valid & rd_ready;
    // A full FIFO still takes a byte if the head leaves in the same cycle
    assign w_push    = w_push_req & ((r_count < DEPTH_C) | w_pop);
    assign w_ovf_set = w_push_req & ~w_push;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= r_shift;
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags: a new error beats a simultaneous clear
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (err_clr) begin
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
                overflow   <= 1'b0;
            end
            if (w_perr_set) parity_err <= 1'b1;
            if (w_ferr_set) frame_err  <= 1'b1;
            if (w_ovf_set)  overflow   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: directed steps followed by random
// frames, compared against a queue-based model of the receiver.
module tb_ps2_rx_fifo;

    localparam int DEPTH = 4;
    localparam int FL    = 8;
    localparam int TO    = 1000;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst, ps2_clk, ps2_dat, rd_ready, err_clr;
    logic          rd_valid, parity_err, frame_err, overflow;
    logic [7:0]    rd_data;
    logic [CW-1:0] fifo_count;

    int checks   = 0;
    int failures = 0;

    logic [7:0] q[$];
    logic       m_perr, m_ferr, m_ovf;

    ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .rd_ready(rd_ready), .err_clr(err_clr), .rd_valid(rd_valid),
        .rd_data(rd_data), .fifo_count(fifo_count), .parity_err(parity_err),
        .frame_err(frame_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"}, 32'(fifo_count), q.size());
        chk({tag, ".valid"}, 32'(rd_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk({tag, ".data"}, 32'(rd_data), 32'(q[0]));
        chk({tag, ".perr"}, 32'(parity_err), 32'(m_perr));
        chk({tag, ".ferr"}, 32'(frame_err), 32'(m_ferr));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    endtask

    // Model of one complete frame: odd parity over data+parity, stop must be 1
    task automatic model_frame(input logic [7:0] b, input logic p, input logic s);
        logic odd;
        odd = ^{b, p};
        if (s && odd) begin
            if (q.size() < DEPTH) q.push_back(b);
            else m_ovf = 1'b1;
        end else begin
            if (!odd) m_perr = 1'b1;
            if (!s)   m_ferr = 1'b1;
        end
    endtask

    // Drive the first n bits of a frame; each bit is 40 clk cycles with the
    // data stable well around the PS/2 falling edge.
    task automatic send_part(input logic [10:0] fr, input int n,
                             input bit pop_at_stop, input int glitch_bit);
        for (int i = 0; i < n; i++) begin
            ps2_dat = fr[i];
            cyc(10);
            ps2_clk = 1'b0;
            if (i == 10 && pop_at_stop) begin
                cyc(2 + FL);
                rd_ready = 1'b1;   // lines up with the stop-bit push cycle
                cyc(1);
                rd_ready = 1'b0;
                cyc(20 - 3 - FL);
            end else begin
                cyc(20);
            end
            ps2_clk = 1'b1;
            cyc(10);
            if (i == glitch_bit) begin
                cyc(5);
                ps2_clk = 1'b0;
                cyc(3);
                ps2_clk = 1'b1;
                cyc(12);
            end
        end
    endtask

    task automatic send(input logic [7:0] b, input logic p, input logic s);
        send_part({s, p, b, 1'b0}, 11, 1'b0, -1);
        ps2_dat = 1'b1;
        cyc(20);
        model_frame(b, p, s);
    endtask

    task automatic send_good(input logic [7:0] b);
        send(b, ~^b, 1'b1);
    endtask

    task automatic pop(input string tag);
        logic [7:0] d;
        if (q.size() == 0) return;
        chk({tag, ".pop_data"}, 32'(rd_data), 32'(q[0]));
        rd_ready = 1'b1;
        cyc(1);
        rd_ready = 1'b0;
        d = q.pop_front();
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        logic       p, s;
        int         kind;
        m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
        rst = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1; rd_ready = 1'b0; err_clr = 1'b0;
        cyc(4);
        rst = 1'b0;
        cyc(1);
        chk("rst.valid", 32'(rd_valid), 0);
        chk("rst.data", 32'(rd_data), 0);
        chk("rst.count", 32'(fifo_count), 0);
        chk("rst.perr", 32'(parity_err), 0);
        chk("rst.ferr", 32'(frame_err), 0);
        chk("rst.ovf", 32'(overflow), 0);

        // Two good frames, read back in order
        send_good(8'h1C);
        send_good(8'hF0);
        chk("good.count2", 32'(fifo_count), 2);
        chk("good.head", 32'(rd_data), 32'h1C);
        check_state("good");
        pop("good1");
        chk("good.second", 32'(rd_data), 32'hF0);
        pop("good2");
        chk("good.empty", 32'(rd_valid), 0);
        check_state("good_end");

        // Bad parity, then clear
        send(8'h1C, 1'b1, 1'b1);
        chk("par.flag", 32'(parity_err), 1);
        check_state("par");
        clear_errs();
        chk("par.clr", 32'(parity_err), 0);

        // Bad stop bit
        send(8'h33, ~^8'h33, 1'b0);
        chk("stop.flag", 32'(frame_err), 1);
        check_state("stop");
        clear_errs();

        // Overflow: fifth byte dropped
        for (int i = 1; i <= 5; i++) send_good(8'(i));
        chk("ovf.count", 32'(fifo_count), DEPTH);
        chk("ovf.flag", 32'(overflow), 1);
        check_state("ovf");
        for (int i = 1; i <= 4; i++) begin
            chk("ovf.order", 32'(rd_data), i);
            pop("ovf");
        end
        check_state("ovf_drain");
        clear_errs();

        // Full FIFO with a pop coinciding with the push
        for (int i = 0; i < 4; i++) send_good(8'h10 + 8'(i));
        send_part({1'b1, ~^8'h77, 8'h77, 1'b0}, 11, 1'b1, -1);
        ps2_dat = 1'b1;
        cyc(20);
        b = q.pop_front();
        q.push_back(8'h77);
        chk("simul.count", 32'(fifo_count), DEPTH);
        chk("simul.ovf", 32'(overflow), 0);
        check_state("simul");
        while (q.size() != 0) pop("simul_drain");
        chk("simul.drained", 32'(rd_valid), 0);

        // Timeout: start + 3 data bits, then clock held high
        send_part({1'b1, 1'b0, 8'h05, 1'b0}, 3, 1'b0, -1);
        ps2_dat = 1'b0;
        cyc(10);
        ps2_clk = 1'b0;
        cyc(20);
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        cyc(FL + TO + 2 - 20);
        chk("to.before", 32'(frame_err), 0);
        cyc(1);
        chk("to.at", 32'(frame_err), 1);
        m_ferr = 1'b1;
        cyc(20);
        send_good(8'h29);
        chk("to.next", 32'(rd_data), 32'h29);
        check_state("to_next");
        pop("to");
        clear_errs();

        // Short glitch on ps2_clk mid-DATA must not shift a bit
        send_part({1'b1, ~^8'h5A, 8'h5A, 1'b0}, 11, 1'b0, 4);
        ps2_dat = 1'b1;
        cyc(20);
        model_frame(8'h5A, ~^8'h5A, 1'b1);
        chk("glitch.data", 32'(rd_data), 32'h5A);
        check_state("glitch");
        pop("glitch");

        // Reset mid-frame with bytes stored and a flag set
        send(8'h1C, 1'b1, 1'b1);
        send_good(8'hA1);
        send_good(8'hB2);
        send_part({1'b1, ~^8'hC3, 8'hC3, 1'b0}, 5, 1'b0, -1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(1);
        q.delete();
        m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
        chk("mrst.count", 32'(fifo_count), 0);
        check_state("mrst");
        send_good(8'h1C);
        chk("mrst.next", 32'(rd_data), 32'h1C);
        check_state("mrst_next");

        // Random frames, random errors, random reads
        for (int n = 0; n < 24; n++) begin
            b    = 8'($urandom);
            kind = int'($urandom_range(0, 7));
            p    = ~^b;
            s    = 1'b1;
            if (kind == 0 || kind == 2) p = ~p;
            if (kind == 1 || kind == 2) s = 1'b0;
            send(b, p, s);
            check_state("rnd");
            for (int k = int'($urandom_range(0, 2)); k > 0; k--) pop("rnd");
            if ($urandom_range(0, 4) == 0) begin
                clear_errs();
                check_state("rnd_clr");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver, clocked entirely in the system clock domain. It synchronises and deglitches the raw PS2_CLK/PS2_DAT pins, decodes 11-bit frames with odd-parity and stop-bit checking, and aborts stalled frames on timeout. Good bytes are buffered in a first-word-fall-through FIFO with a valid/ready read port. It sits between the keyboard pins and the CPU-side peripheral register block, and replaces the older pin-clocked receiver.

## Interface
- FIFO_DEPTH, 8: receive FIFO entries; power of two, ≥2.
- FILTER_LEN, 8: consecutive clk samples a synchronised ps2_clk level must hold before the filtered clock follows it; ≥1.
- TIMEOUT_CYCLES, 50000: clk cycles allowed between falling edges inside a frame (1 ms at 50 MHz).
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2_dat  in  1  raw PS/2 data pin, asynchronous.
- rd_ready  in  1  consumer accepts rd_data this cycle.
- err_clr  in  1  one-cycle pulse; clears all sticky error flags.
- rd_valid  out  1  FIFO non-empty.
- rd_data  out  8  FIFO head byte; valid only when rd_valid=1.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  bytes currently stored.
- parity_err  out  1  sticky; a frame failed odd parity.
- frame_err  out  1  sticky; bad stop bit or timeout abort.
- overflow  out  1  sticky; a good byte was dropped because the FIFO was full.

## Operation
- Input path: 2-flop synchroniser on each pin. Filtered clock resets to 1 and changes only after the synchronised ps2_clk has differed from it for FILTER_LEN consecutive cycles. A falling edge is a 1→0 transition of the filtered clock, producing a single-cycle `fall` strobe. Data is sampled from synchronised ps2_dat in the `fall` cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with dat=0 (start bit), clear the shift register and bit counter, then go to DATA. On `fall` with dat=1, stay in IDLE.
  - DATA: on each `fall`, shift dat in LSB-first. After the 8th bit, go to PARITY.
  - PARITY: on `fall`, capture the parity bit and go to STOP.
  - STOP: on `fall`, evaluate the frame and return to IDLE.
    - Frame good when stop=1 and (^data ^ parity)=1. A good frame pushes the byte.
    - Parity bad: set parity_err, drop the byte.
    - Stop=0: set frame_err, drop the byte. Both flags may set together.
- Timeout: the watchdog counter runs in every state except IDLE and reloads on each `fall`. When it reaches TIMEOUT_CYCLES, go to IDLE, set frame_err, and discard the partial byte.
- FIFO behaviour:
  - Pop when rd_valid && rd_ready.
  - A push is accepted when fifo_count<FIFO_DEPTH, or when a pop occurs in the same cycle. In the same-cycle case fifo_count is unchanged.
  - A push rejected because the FIFO is full sets overflow; the stored contents are untouched.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- Sticky flags: err_clr clears them. If err_clr and a new error occur in the same cycle, the flag ends up set.

## Timing
- Reset values:
  - All outputs 0: rd_valid=0, rd_data=0, fifo_count=0, and all three error flags 0.
  - FSM in IDLE, filtered clock 1, watchdog 0.
- Reset mid-frame discards the partial frame and any FIFO contents. A frame still in progress when rst deasserts is not recovered:
  - trailing data bits read as start bits are either rejected at STOP or terminated by the timeout;
  - either way the receiver resynchronises before the next good frame.
- Pin-to-`fall` latency: 2 synchroniser cycles + FILTER_LEN cycles.
- Push occurs in the `fall` cycle of the stop bit. rd_valid and rd_data update on the following clk edge.
- rd_data is combinational from the head entry (first-word fall-through). A pop advances the head on the next edge.
- fifo_count updates one edge after each push or pop.
- Timeout fires exactly TIMEOUT_CYCLES clk cycles after the last `fall`.

## Test plan
- Good frames: send 0x1C (parity 0), then 0xF0 (parity 1), rd_ready=0 → fifo_count=2, rd_data=0x1C. Pulse rd_ready → rd_data=0xF0; second pop → rd_valid=0. No error flags set.
- Bad parity: send 0x1C with parity bit 1 → parity_err=1, fifo_count stays 0. Pulse err_clr → parity_err=0.
- Overflow at FIFO_DEPTH=4: send 0x01..0x05 with no reads → fifo_count=4, overflow=1. Reads return 0x01..0x04 in order.
- Timeout at TIMEOUT_CYCLES=1000: send start + 3 data bits, then hold ps2_clk high → frame_err=1 exactly 1000 cycles after the last `fall`, FSM back in IDLE. A following good frame with 0x29 is received correctly.
- Glitch and simultaneous events:
  - With FILTER_LEN=8, inject a 3-cycle low pulse on ps2_clk mid-DATA → no bit shifted; 0x5A is still received correctly.
  - With the FIFO full, push coincides with a pop → fifo_count stays FIFO_DEPTH, the new byte is stored, overflow stays 0.
- Reset mid-frame: assert rst for 1 cycle after 4 data bits with 2 bytes stored → fifo_count=0, all flags 0. The next 0x1C frame is received.
